data_bus_responder: RTL and testbench

Memory-side responder for the single-cycle CPU's external data bus. It decodes each bus access into one of two targets: word-addressed data RAM, or a small memory-mapped I/O page. The I/O page holds a console TX FIFO with a valid/ready drain port, a free-running cycle timer, and a GPIO output register. It sits between the CPU's AddressBus/DataBus/ControlBus and the board-level peripherals, replacing a bare data memory.

---
 rtl/data_bus_responder.sv | 148 ++++++++++++++
 tb/tb_data_bus_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-bus responder: word-addressed RAM plus a 4-register MMIO page
// (console TX FIFO, cycle timer, GPIO). Reads are combinational, writes commit on clk.
module data_bus_responder #(
  parameter int unsigned RAM_ADDR_W = 10,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AddressBus,
  input  logic [31:0] DataBusIn,
  output logic [31:0] DataBusOut,
  input  logic [2:0]  ControlBus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] gpio_out,
  output logic        bus_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OFF_CONSOLE_DATA   = 2'd0,
    OFF_CONSOLE_STATUS = 2'd1,
    OFF_TIMER          = 2'd2,
    OFF_GPIO           = 2'd3
  } mmio_off_t;

  logic [31:0] ram [2**RAM_ADDR_W];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   timer;
  logic [31:0]   gpio_q;
  logic          bus_err_q;

  logic      wr_en, rd_en;
  logic      ram_hit, mmio_hit, unmapped;
  mmio_off_t offset;
  logic      full, empty;
  logic      pop, push_req, push_ok;
  logic      status_clr, timer_wr, gpio_wr, err_set;
  logic [7:0] count8;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic      unused_ok;

  assign wr_en     = ControlBus[2];
  assign rd_en     = ControlBus[1];
  assign unused_ok = ControlBus[0];

  assign ram_hit  = (AddressBus[31:RAM_ADDR_W] == '0);
  assign mmio_hit = !ram_hit && (AddressBus[31:2] == MMIO_BASE[31:2]);
  assign unmapped = !ram_hit && !mmio_hit;
  assign offset   = mmio_off_t'(AddressBus[1:0]);
  assign ram_idx  = AddressBus[RAM_ADDR_W-1:0];

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign gpio_out = gpio_q;
  assign bus_err  = bus_err_q;
  assign count8   = 8'(count);

  // Pop is resolved first so a full FIFO can still take a push on a draining edge.
  assign pop        = tx_valid && tx_ready;
  assign push_req   = wr_en && mmio_hit && (offset == OFF_CONSOLE_DATA);
  assign push_ok    = push_req && (!full || pop);
  assign status_clr = wr_en && mmio_hit && (offset == OFF_CONSOLE_STATUS) && DataBusIn[2];
  assign timer_wr   = wr_en && mmio_hit && (offset == OFF_TIMER);
  assign gpio_wr    = wr_en && mmio_hit && (offset == OFF_GPIO);
  assign err_set    = ((wr_en || rd_en) && unmapped) || (wr_en && rd_en);

  always_comb begin
    DataBusOut = '0;
    if (rd_en) begin
      if (ram_hit) begin
        DataBusOut = ram[ram_idx];
      end else if (mmio_hit) begin
        unique case (offset)
          OFF_CONSOLE_DATA:   DataBusOut = '0;
          OFF_CONSOLE_STATUS: DataBusOut = {16'd0, count8, 5'd0, overflow, full, empty};
          OFF_TIMER:          DataBusOut = timer;
          OFF_GPIO:           DataBusOut = gpio_q;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; writes are simply suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (rst && wr_en && ram_hit) begin
      ram[ram_idx] <= DataBusIn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      fifo_mem[wr_ptr] <= DataBusIn[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      timer     <= '0;
      gpio_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (status_clr) begin
        overflow <= 1'b0;
      end
      if (timer_wr) begin
        timer <= DataBusIn;
      end else begin
        timer <= timer + 32'd1;
      end
      if (gpio_wr) begin
        gpio_q <= DataBusIn;
      end
      if (err_set) begin
        bus_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder with hand-computed expectations.
module tb_data_bus_responder;

  localparam logic [31:0] A_DATA  = 32'hFFFF_FF00;
  localparam logic [31:0] A_STAT  = 32'hFFFF_FF01;
  localparam logic [31:0] A_TIMER = 32'hFFFF_FF02;
  localparam logic [31:0] A_GPIO  = 32'hFFFF_FF03;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AddressBus;
  logic [31:0] DataBusIn;
  logic [31:0] DataBusOut;
  logic [2:0]  ControlBus;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] gpio_out;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  data_bus_responder #(
    .RAM_ADDR_W (10),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .AddressBus (AddressBus),
    .DataBusIn  (DataBusIn),
    .DataBusOut (DataBusOut),
    .ControlBus (ControlBus),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .gpio_out   (gpio_out),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write commits at the next rising edge; returns 1 time unit after it.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    AddressBus = addr;
    DataBusIn  = data;
    ControlBus = 3'b100;
    @(posedge clk);
    #1;
    ControlBus = 3'b000;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    AddressBus = addr;
    ControlBus = 3'b010;
    #1;
    check(tag, DataBusOut, exp);
    ControlBus = 3'b000;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    rst        = 1'b0;
    AddressBus = '0;
    DataBusIn  = '0;
    ControlBus = 3'b000;
    tx_ready   = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_gpio", gpio_out, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_dbo_idle", DataBusOut, 32'd0);
    rst = 1'b1;

    // Timer counts edges since reset
    bus_read("timer_n0", A_TIMER, 32'd0);
    repeat (5) tick();
    bus_read("timer_n5", A_TIMER, 32'd5);
    bus_write(A_TIMER, 32'hFFFF_FFFE);
    bus_read("timer_load", A_TIMER, 32'hFFFF_FFFE);
    tick();
    bus_read("timer_max", A_TIMER, 32'hFFFF_FFFF);
    tick();
    bus_read("timer_wrap", A_TIMER, 32'd0);

    // RAM round trip
    bus_write(32'd0, 32'h0BAD_F00D);
    bus_write(32'd6, 32'h1234_5678);
    bus_write(32'd5, 32'hDEAD_BEEF);
    bus_read("ram5", 32'd5, 32'hDEAD_BEEF);
    bus_read("ram6", 32'd6, 32'h1234_5678);
    check("ram_bus_err", 32'(bus_err), 32'd0);

    // GPIO
    bus_write(A_GPIO, 32'd5);
    check("gpio_out", gpio_out, 32'd5);
    bus_read("gpio_rd", A_GPIO, 32'd5);

    // Console flow
    check("con_empty_valid", 32'(tx_valid), 32'd0);
    bus_write(A_DATA, 32'h41);
    check("con_no_fallthru", 32'(tx_valid), 32'd1);
    bus_write(A_DATA, 32'h42);
    bus_write(A_DATA, 32'hFFFF_FF43);
    bus_read("con_status3", A_STAT, 32'h0000_0300);
    bus_read("con_data_rd", A_DATA, 32'd0);
    check("con_hold_a", 32'(tx_data), 32'h41);
    tick();
    check("con_stable_a", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    tick();
    check("con_pop_b", 32'(tx_data), 32'h42);
    tick();
    check("con_pop_c", 32'(tx_data), 32'h43);
    tick();
    check("con_drained", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    bus_read("con_status_empty", A_STAT, 32'h0000_0001);

    // Overflow: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) begin
      bus_write(A_DATA, 32'h10 + 32'(i));
    end
    bus_read("ovf_status", A_STAT, 32'h0000_0806);
    check("ovf_head", 32'(tx_data), 32'h10);
    bus_write(A_STAT, 32'h0000_0004);
    bus_read("ovf_cleared", A_STAT, 32'h0000_0802);
    tx_ready = 1'b1;
    bus_write(A_DATA, 32'h20);
    bus_read("full_pushpop", A_STAT, 32'h0000_0802);
    drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(tx_data), 32'(drain_exp[i]));
      tick();
    end
    check("drain_done", 32'(tx_valid), 32'd0);

    // Push into empty with tx_ready high
    bus_write(A_DATA, 32'h55);
    check("empty_pushpop_valid", 32'(tx_valid), 32'd1);
    check("empty_pushpop_data", 32'(tx_data), 32'h55);
    tick();
    check("empty_pushpop_gone", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Unmapped read
    bus_read("unmapped_rd", 32'h8000_0000, 32'd0);
    AddressBus = 32'h8000_0000;
    ControlBus = 3'b010;
    tick();
    ControlBus = 3'b000;
    check("unmapped_rd_err", 32'(bus_err), 32'd1);

    // Reset mid-operation with bytes queued and a push in flight
    bus_write(A_DATA, 32'h61);
    bus_write(A_DATA, 32'h62);
    bus_write(A_DATA, 32'h63);
    check("pre_rst_valid", 32'(tx_valid), 32'd1);
    AddressBus = A_DATA;
    DataBusIn  = 32'h77;
    ControlBus = 3'b100;
    rst = 1'b0;
    tick();
    ControlBus = 3'b000;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_gpio", gpio_out, 32'd0);
    check("mid_rst_err", 32'(bus_err), 32'd0);
    rst = 1'b1;
    bus_read("mid_rst_status", A_STAT, 32'h0000_0001);
    bus_read("mid_rst_ram5", 32'd5, 32'hDEAD_BEEF);

    // Simultaneous read and write
    AddressBus = 32'd5;
    DataBusIn  = 32'h1111_2222;
    ControlBus = 3'b110;
    #1;
    check("rw_prewrite", DataBusOut, 32'hDEAD_BEEF);
    tick();
    ControlBus = 3'b000;
    check("rw_err", 32'(bus_err), 32'd1);
    bus_read("rw_written", 32'd5, 32'h1111_2222);

    // Unmapped write
    do_reset();
    check("uw_err_clear", 32'(bus_err), 32'd0);
    bus_write(32'h8000_0000, 32'hAAAA_5555);
    check("uw_err", 32'(bus_err), 32'd1);
    bus_read("uw_ram0", 32'd0, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
